// File: rtl/hcsr04_pkg.sv
// rtl/hcsr04_pkg.sv - shared state codes, widths, defaults and BCD conversion
package hcsr04_pkg;

    // FSM state codes, also exported on db_estado
    localparam logic [3:0] ST_INICIAL      = 4'b0000;
    localparam logic [3:0] ST_ESPERA       = 4'b0001;
    localparam logic [3:0] ST_MEDE_TRIGGER = 4'b0010;
    localparam logic [3:0] ST_CALCULA      = 4'b0011;
    localparam logic [3:0] ST_ATRASO       = 4'b0100;
    localparam logic [3:0] ST_ECO          = 4'b0101;
    localparam logic [3:0] ST_FIM          = 4'b0110;

    // Timing defaults for a 50 MHz clock
    localparam int CICLOS_TRIGGER_MIN_DEF = 500;
    localparam int CICLOS_ATRASO_DEF      = 20000;
    localparam int CICLOS_POR_CM_DEF      = 2941;
    localparam int DIST_MAX_DEF           = 400;
    localparam int CICLOS_TIMEOUT_DEF     = 1900000;

    localparam int W_DIST_BCD = 12;
    localparam int W_DIST_BIN = 9;
    localparam int W_LARGURA  = 22;

    typedef struct packed {
        logic                  valido;
        logic [W_DIST_BIN-1:0] cm;
    } dist_t;

    // Three BCD digits to binary centimetres. Any digit above 9 marks the
    // value invalid, so the 10-bit sum only has to be right for 0..999.
    function automatic dist_t bcd_para_bin(input logic [W_DIST_BCD-1:0] bcd,
                                           input int dist_max);
        logic [3:0] c;
        logic [3:0] d;
        logic [3:0] u;
        logic [9:0] soma;
        dist_t      r;
        c        = bcd[11:8];
        d        = bcd[7:4];
        u        = bcd[3:0];
        soma     = 10'(c) * 10'd100 + 10'(d) * 10'd10 + 10'(u);
        r.cm     = soma[W_DIST_BIN-1:0];
        r.valido = (c <= 4'd9) && (d <= 4'd9) && (u <= 4'd9) &&
                   (soma != 10'd0) && (int'(soma) <= dist_max);
        return r;
    endfunction

endpackage

// File: rtl/hcsr04_emulador_if.sv
// rtl/hcsr04_emulador_if.sv - trigger/echo bus between range meter and sensor
interface hcsr04_emulador_if;
    import hcsr04_pkg::*;

    logic                  trigger;
    logic [W_DIST_BCD-1:0] distancia;
    logic                  echo;
    logic                  ocupado;
    logic [3:0]            db_estado;

    // Range meter side: fires trigger, selects distance, watches echo
    modport master (
        output trigger,
        output distancia,
        input  echo,
        input  ocupado,
        input  db_estado
    );

    // Sensor emulator side
    modport slave (
        input  trigger,
        input  distancia,
        output echo,
        output ocupado,
        output db_estado
    );

endinterface

// File: rtl/contador_largura.sv
// rtl/contador_largura.sv - loadable down-counter with zero flag for interval timing
module contador_largura
    import hcsr04_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 i_load,
    input  logic                 i_enable,
    input  logic [W_LARGURA-1:0] i_valor,
    output logic                 o_zero
);

    logic [W_LARGURA-1:0] r_contagem;

    // Load has priority; otherwise count down while enabled
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_contagem <= '0;
        end else if (i_load) begin
            r_contagem <= i_valor;
        end else if (i_enable) begin
            r_contagem <= r_contagem - W_LARGURA'(1);
        end
    end

    assign o_zero = (r_contagem == '0);

endmodule

// File: rtl/hcsr04_emulador.sv
// rtl/hcsr04_emulador.sv - HC-SR04 responder: trigger in, distance-coded echo out
module hcsr04_emulador
    import hcsr04_pkg::*;
#(
    parameter int CICLOS_TRIGGER_MIN = CICLOS_TRIGGER_MIN_DEF,
    parameter int CICLOS_ATRASO      = CICLOS_ATRASO_DEF,
    parameter int CICLOS_POR_CM      = CICLOS_POR_CM_DEF,
    parameter int DIST_MAX           = DIST_MAX_DEF,
    parameter int CICLOS_TIMEOUT     = CICLOS_TIMEOUT_DEF
)(
    input  logic               clock,
    input  logic               reset,
    hcsr04_emulador_if.slave   bus
);

    localparam int                  W_TRIG   = $clog2(CICLOS_TRIGGER_MIN + 1);
    localparam logic [W_TRIG-1:0]   TRIG_MIN = W_TRIG'(CICLOS_TRIGGER_MIN);

    logic [3:0]            r_estado;
    logic [W_TRIG-1:0]     r_cont_trig;
    logic [W_DIST_BCD-1:0] r_dist_bcd;
    logic [W_LARGURA-1:0]  r_largura;

    dist_t                 w_dist;
    logic                  w_load;
    logic                  w_enable;
    logic                  w_zero;
    logic [W_LARGURA-1:0]  w_valor;

    assign w_dist = bcd_para_bin(r_dist_bcd, DIST_MAX);

    // The shared counter is loaded with N-1 so that the zero flag marks the
    // last clock of an N-clock interval: delay on entering atraso, echo
    // width on the atraso->eco transition.
    assign w_load   = (r_estado == ST_CALCULA) || ((r_estado == ST_ATRASO) && w_zero);
    assign w_valor  = (r_estado == ST_CALCULA) ? W_LARGURA'(CICLOS_ATRASO - 1)
                                               : r_largura - W_LARGURA'(1);
    assign w_enable = ((r_estado == ST_ATRASO) || (r_estado == ST_ECO)) && !w_zero;

    contador_largura u_contador (
        .clock    (clock),
        .reset    (reset),
        .i_load   (w_load),
        .i_enable (w_enable),
        .i_valor  (w_valor),
        .o_zero   (w_zero)
    );

    // Main sequencer: trigger qualification, distance latch, delay and echo
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_estado    <= ST_INICIAL;
            r_cont_trig <= '0;
            r_dist_bcd  <= '0;
            r_largura   <= '0;
        end else begin
            case (r_estado)
                ST_INICIAL: begin
                    r_estado <= ST_ESPERA;
                end
                ST_ESPERA: begin
                    // The first high sample already counts toward the minimum
                    r_cont_trig <= bus.trigger ? W_TRIG'(1) : '0;
                    if (bus.trigger) begin
                        r_estado <= ST_MEDE_TRIGGER;
                    end
                end
                ST_MEDE_TRIGGER: begin
                    if (bus.trigger) begin
                        if (r_cont_trig != TRIG_MIN) begin
                            r_cont_trig <= r_cont_trig + W_TRIG'(1);
                        end
                    end else if (r_cont_trig == TRIG_MIN) begin
                        r_dist_bcd <= bus.distancia;
                        r_estado   <= ST_CALCULA;
                    end else begin
                        r_estado <= ST_ESPERA;
                    end
                end
                ST_CALCULA: begin
                    r_largura <= w_dist.valido
                               ? W_LARGURA'(int'(w_dist.cm) * CICLOS_POR_CM)
                               : W_LARGURA'(CICLOS_TIMEOUT);
                    r_estado  <= ST_ATRASO;
                end
                ST_ATRASO: begin
                    if (w_zero) begin
                        r_estado <= ST_ECO;
                    end
                end
                ST_ECO: begin
                    if (w_zero) begin
                        r_estado <= ST_FIM;
                    end
                end
                ST_FIM: begin
                    r_estado <= ST_ESPERA;
                end
                default: begin
                    r_estado <= ST_INICIAL;
                end
            endcase
        end
    end

    // Outputs decode the state register directly so an async reset clears them at once
    assign bus.echo      = (r_estado == ST_ECO);
    assign bus.ocupado   = (r_estado == ST_CALCULA) || (r_estado == ST_ATRASO) ||
                           (r_estado == ST_ECO)     || (r_estado == ST_FIM);
    assign bus.db_estado = r_estado;

endmodule

// File: tb/tb_hcsr04_emulador.sv
// tb/tb_hcsr04_emulador.sv - scoreboard bench for the HC-SR04 emulator
module tb_hcsr04_emulador;
    import hcsr04_pkg::*;

    localparam int P_TRIG    = 8;
    localparam int P_ATRASO  = 30;
    localparam int P_POR_CM  = 3;
    localparam int P_DMAX    = 400;
    localparam int P_TIMEOUT = 1500;
    // Trigger fall is recorded at cycle k; the edge k+1 first samples 0 and
    // echo rises on edge k+1+P_ATRASO+1, seen at the following negedge.
    localparam int EXP_DELAY = P_ATRASO + 2;

    typedef struct {
        int fall_cyc;
        int width;
    } exp_t;

    logic clk;
    logic rst;
    int   cyc = 0;
    int   n_rises = 0;
    logic echo_prev = 1'b0;
    int   vec = 0;
    int   err = 0;
    exp_t sb[$];

    logic [11:0] tbl_dist [4] = '{12'h074, 12'h075, 12'h001, 12'h400};
    logic [11:0] tbl_inv  [3] = '{12'h0A5, 12'h000, 12'h401};

    hcsr04_emulador_if bus ();

    hcsr04_emulador #(
        .CICLOS_TRIGGER_MIN (P_TRIG),
        .CICLOS_ATRASO      (P_ATRASO),
        .CICLOS_POR_CM      (P_POR_CM),
        .DIST_MAX           (P_DMAX),
        .CICLOS_TIMEOUT     (P_TIMEOUT)
    ) dut (
        .clock (clk),
        .reset (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.echo === 1'b1 && echo_prev !== 1'b1) n_rises <= n_rises + 1;
        echo_prev <= bus.echo;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, vectors %0d", vec);
        $fatal(1, "watchdog");
    end

    // Reference echo width from the BCD distance
    function automatic int exp_width(input logic [11:0] bcd);
        int h, t, u, d;
        h = int'(bcd[11:8]);
        t = int'(bcd[7:4]);
        u = int'(bcd[3:0]);
        if (h > 9 || t > 9 || u > 9) return P_TIMEOUT;
        d = 100 * h + 10 * t + u;
        if (d == 0 || d > P_DMAX) return P_TIMEOUT;
        return d * P_POR_CM;
    endfunction

    task automatic pulse(input int n, output int fall_cyc);
        @(posedge clk);
        #1 bus.trigger = 1'b1;
        repeat (n) @(posedge clk);
        #1 bus.trigger = 1'b0;
        fall_cyc = cyc;
    endtask

    task automatic measure_echo(output bit ok, output int rise_cyc, output int width);
        int budget;
        ok = 1'b0; rise_cyc = 0; width = 0; budget = 0;
        while (bus.echo !== 1'b1 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (bus.echo !== 1'b1) return;
        rise_cyc = cyc;
        budget = 0;
        while (bus.echo === 1'b1 && budget < 5000) begin
            @(negedge clk);
            budget++;
        end
        if (bus.echo === 1'b1) return;
        width = cyc - rise_cyc;
        ok = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.trigger = 1'b0;
        bus.distancia = 12'h000;
        repeat (3) @(posedge clk);
        @(negedge clk);
        vec++; if (bus.echo !== 1'b0) begin err++; $display("FAIL reset_echo: got %b expected 0", bus.echo); end
        vec++; if (bus.ocupado !== 1'b0) begin err++; $display("FAIL reset_ocupado: got %b expected 0", bus.ocupado); end
        vec++; if (bus.db_estado !== 4'b0000) begin err++; $display("FAIL reset_estado: got %b expected 0000", bus.db_estado); end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        vec++; if (bus.db_estado !== 4'b0001) begin err++; $display("FAIL reset_to_espera: got %b expected 0001", bus.db_estado); end
    endtask

    task automatic test_basic();
        int f, r, w; bit ok; exp_t e;
        bus.distancia = 12'h100;
        pulse(12, f);
        sb.push_back('{fall_cyc: f, width: exp_width(12'h100)});
        repeat (2) @(posedge clk);
        @(negedge clk);
        vec++; if (bus.db_estado !== 4'b0100) begin err++; $display("FAIL basic_atraso_state: got %b expected 0100", bus.db_estado); end
        vec++; if (bus.ocupado !== 1'b1) begin err++; $display("FAIL basic_ocupado: got %b expected 1", bus.ocupado); end
        measure_echo(ok, r, w);
        e = sb.pop_front();
        vec++; if (!ok) begin err++; $display("FAIL basic_timeout: got no echo expected width %0d", e.width); end
        vec++; if (r - e.fall_cyc != EXP_DELAY) begin err++; $display("FAIL basic_delay: got %0d expected %0d", r - e.fall_cyc, EXP_DELAY); end
        vec++; if (w != e.width) begin err++; $display("FAIL basic_width: got %0d expected %0d", w, e.width); end
        vec++; if (bus.db_estado !== 4'b0110) begin err++; $display("FAIL basic_fim: got %b expected 0110", bus.db_estado); end
        @(negedge clk);
        vec++; if (bus.db_estado !== 4'b0001) begin err++; $display("FAIL basic_espera: got %b expected 0001", bus.db_estado); end
        vec++; if (bus.ocupado !== 1'b0) begin err++; $display("FAIL basic_idle: got %b expected 0", bus.ocupado); end
    endtask

    task automatic test_distances();
        int f, r, w; bit ok; exp_t e;
        for (int i = 0; i < 4; i++) begin
            bus.distancia = tbl_dist[i];
            pulse(12, f);
            sb.push_back('{fall_cyc: f, width: exp_width(tbl_dist[i])});
            measure_echo(ok, r, w);
            e = sb.pop_front();
            vec++; if (!ok || w != e.width) begin err++; $display("FAIL dist_width %h: got %0d expected %0d", tbl_dist[i], w, e.width); end
            vec++; if (r - e.fall_cyc != EXP_DELAY) begin err++; $display("FAIL dist_delay %h: got %0d expected %0d", tbl_dist[i], r - e.fall_cyc, EXP_DELAY); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_short_trigger();
        int f, r, w, n0; bit ok, busy; exp_t e;
        bus.distancia = 12'h100;
        @(posedge clk);
        n0 = n_rises;
        busy = 1'b0;
        pulse(P_TRIG - 1, f);
        repeat (P_ATRASO + 20) begin
            @(negedge clk);
            if (bus.ocupado !== 1'b0) busy = 1'b1;
        end
        vec++; if (busy) begin err++; $display("FAIL short_ocupado: got 1 expected 0"); end
        vec++; if (n_rises != n0) begin err++; $display("FAIL short_echo: got %0d echoes expected 0", n_rises - n0); end
        vec++; if (bus.db_estado !== 4'b0001) begin err++; $display("FAIL short_state: got %b expected 0001", bus.db_estado); end
        pulse(P_TRIG, f);
        sb.push_back('{fall_cyc: f, width: exp_width(12'h100)});
        measure_echo(ok, r, w);
        e = sb.pop_front();
        vec++; if (!ok || w != e.width) begin err++; $display("FAIL min_trigger_width: got %0d expected %0d", w, e.width); end
        vec++; if (r - e.fall_cyc != EXP_DELAY) begin err++; $display("FAIL min_trigger_delay: got %0d expected %0d", r - e.fall_cyc, EXP_DELAY); end
        repeat (3) @(negedge clk);
    endtask

    task automatic test_invalid();
        int f, r, w; bit ok; exp_t e;
        for (int i = 0; i < 3; i++) begin
            bus.distancia = tbl_inv[i];
            pulse(12, f);
            sb.push_back('{fall_cyc: f, width: exp_width(tbl_inv[i])});
            measure_echo(ok, r, w);
            e = sb.pop_front();
            vec++; if (!ok || w != e.width) begin err++; $display("FAIL invalid_width %h: got %0d expected %0d", tbl_inv[i], w, e.width); end
            repeat (3) @(negedge clk);
        end
    endtask

    task automatic test_back_to_back();
        int f, f2, r, w, n0; bit ok; exp_t e;
        bus.distancia = 12'h100;
        @(posedge clk);
        n0 = n_rises;
        pulse(12, f);
        sb.push_back('{fall_cyc: f, width: exp_width(12'h100)});
        fork
            measure_echo(ok, r, w);
            begin
                repeat (10) @(posedge clk);
                #1 bus.distancia = 12'h074;
                repeat (40) @(posedge clk);
                pulse(12, f2);
            end
        join
        e = sb.pop_front();
        vec++; if (!ok || w != e.width) begin err++; $display("FAIL b2b_width: got %0d expected %0d", w, e.width); end
        vec++; if (r - e.fall_cyc != EXP_DELAY) begin err++; $display("FAIL b2b_delay: got %0d expected %0d", r - e.fall_cyc, EXP_DELAY); end
        repeat (P_ATRASO + 50) @(negedge clk);
        vec++; if (n_rises != n0 + 1) begin err++; $display("FAIL b2b_extra_echo: got %0d echoes expected 1", n_rises - n0); end
        vec++; if (bus.db_estado !== 4'b0001) begin err++; $display("FAIL b2b_state: got %b expected 0001", bus.db_estado); end
    endtask

    task automatic test_reset_mid_eco();
        int f, r, w, budget; bit ok; exp_t e;
        bus.distancia = 12'h100;
        pulse(12, f);
        budget = 0;
        while (bus.echo !== 1'b1 && budget < 500) begin
            @(negedge clk);
            budget++;
        end
        vec++; if (bus.echo !== 1'b1) begin err++; $display("FAIL mid_eco_reached: got %b expected 1", bus.echo); end
        repeat (20) @(negedge clk);
        rst = 1'b1;
        #1;
        vec++; if (bus.echo !== 1'b0) begin err++; $display("FAIL mid_eco_echo: got %b expected 0", bus.echo); end
        vec++; if (bus.db_estado !== 4'b0000) begin err++; $display("FAIL mid_eco_state: got %b expected 0000", bus.db_estado); end
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        pulse(12, f);
        sb.push_back('{fall_cyc: f, width: exp_width(12'h100)});
        measure_echo(ok, r, w);
        e = sb.pop_front();
        vec++; if (!ok || w != e.width) begin err++; $display("FAIL after_reset_width: got %0d expected %0d", w, e.width); end
        vec++; if (r - e.fall_cyc != EXP_DELAY) begin err++; $display("FAIL after_reset_delay: got %0d expected %0d", r - e.fall_cyc, EXP_DELAY); end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_distances();
        test_short_trigger();
        test_invalid();
        test_back_to_back();
        test_reset_mid_eco();
        $display("== %0d vectors applied, %0d miscompares ==", vec, err);
        $finish;
    end

endmodule

// File: doc/hcsr04_emulador.md
Name: hcsr04_emulador

Overview:
- Synthesizable model of the HC-SR04 ultrasonic sensor: the responder end of the trigger/echo protocol driven by the range-measurement interface.
- Receives the `trigger` pulse and, after a fixed burst delay, drives an `echo` pulse whose width encodes a BCD distance selected on board switches.
- Used in closed-loop FPGA tests of the range meter without physical hardware, and as a reusable stimulus in benches.

Parameters:
- CICLOS_TRIGGER_MIN, 500, minimum trigger high time in clocks (10 us at 50 MHz).
- CICLOS_ATRASO, 20000, delay from trigger fall to echo rise (400 us).
- CICLOS_POR_CM, 2941, echo clocks per centimetre (58.82 us/cm).
- DIST_MAX, 400, largest valid distance in cm.
- CICLOS_TIMEOUT, 1900000, echo width for out-of-range or invalid distance (38 ms).

Ports:
- clock  in  1  system clock, 50 MHz.
- reset  in  1  asynchronous, active-high.
- trigger  in  1  trigger pulse from the range interface (synchronous to clock).
- distancia  in  12  3-digit BCD distance in cm (hundreds, tens, units).
- echo  out  1  emulated echo pulse.
- ocupado  out  1  high from trigger acceptance until echo ends.
- db_estado  out  4  current FSM state code.

Behaviour:
- Reset (async): echo=0, ocupado=0, db_estado=0000 (inicial); all counters cleared. Reset mid-echo drops echo in the same instant.
- FSM states and codes:
  - inicial 0000: go to espera 0001.
  - espera 0001: waits for trigger=1 → mede_trigger 0010.
  - mede_trigger 0010: counts clocks with trigger=1; counter saturates at CICLOS_TRIGGER_MIN.
    - trigger=0 with count < CICLOS_TRIGGER_MIN → espera (pulse ignored, echo never asserted).
    - trigger=0 with count == CICLOS_TRIGGER_MIN → latch distancia, → calcula 0011.
    - A trigger held arbitrarily long is accepted on its falling edge.
  - calcula 0011 (1 clock): BCD→binary, dist = 100·H + 10·T + U (9 bits).
    - Invalid if any digit > 9, dist == 0, or dist > DIST_MAX.
    - Largura (22 bits) = dist·CICLOS_POR_CM if valid, else CICLOS_TIMEOUT.
    - → atraso 0100.
  - atraso 0100: counts CICLOS_ATRASO clocks, → eco 0101.
  - eco 0101: echo=1 for exactly Largura clocks, → fim 0110.
  - fim 0110: echo=0, one clock, → espera.
- ocupado=1 in states calcula, atraso, eco and fim.
- Timing: echo rises exactly CICLOS_ATRASO+1 rising edges after the edge that first samples trigger=0. Width is exact to the clock.
- distancia changes after the latch have no effect on the current pulse.
- trigger activity while ocupado=1 is ignored. A trigger still high when returning to espera restarts counting from zero.
- The multiply uses a constant-coefficient product; there is no overflow, since 400·2941 = 1176400 < 2^22.

Decomposition:
- Shared package hcsr04_pkg: state encodings (4-bit), CICLOS_* defaults, DIST_MAX, bus widths (distance 12 BCD / 9 binary, largura 22).
- One sub-module contador_largura: 22-bit loadable down-counter (load, enable, zero flag). It is reused for both the atraso and eco intervals.
- The trigger counter and BCD conversion stay inline.

Test Plan:
- distancia=12'h100, 20 us trigger → echo rises 400 us after trigger fall, width 294100 clocks (5882 us); db_estado returns 0001.
- distancia=12'h074 → echo width 217634 clocks (4352.68 us); a following distancia=12'h075 → 220575 clocks.
- Trigger high for 499 clocks → no echo, ocupado stays 0; then a 500-clock trigger → echo produced.
- distancia=12'h0A5 (invalid digit), 12'h000 and 12'h401 → each gives echo width 1900000 clocks.
- Second trigger pulse during eco, and distancia changed during atraso → echo width unchanged, second trigger ignored, no extra echo.
- Reset asserted mid-eco → echo=0 and db_estado=0000 immediately; after release, a new trigger gives a normal echo.
